// File: rtl/uart_rx_stream.sv
// ============================================================================
//  Module   : uart_rx_stream
//  Purpose  : Asynchronous serial receiver (start / DATA_BITS / [parity] /
//             stop) that presents each received byte on a valid/ready stream.
//             Bits are sampled at their centres using a clock-cycle counter
//             derived from CLK_FREQ / BAUD.
//  Ports    : clk          - system clock
//             n_reset      - asynchronous active-low reset
//             uart_rx_pin  - raw serial line, idles high, asynchronous
//             data         - received byte, LSB first on the wire
//             valid        - data holds an unconsumed byte
//             ready        - consumer accepts data
//             framing_err  - 1-cycle pulse, stop bit sampled low
//             overrun      - 1-cycle pulse, completed byte dropped
//             parity_err   - 1-cycle pulse, even-parity mismatch
//                            (only with UART_RX_STREAM_PARITY_EN)
//  Options  : `define UART_RX_STREAM_PARITY_EN adds an even-parity bit
//             between the data bits and the stop bit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_stream #(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 uart_rx_pin,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 framing_err,
  output logic                 overrun
`ifdef UART_RX_STREAM_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  localparam logic [CW-1:0] C_HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] C_CPB_M1   = CW'(CPB - 1);
  localparam logic [3:0]    C_LAST_BIT = 4'(DATA_BITS - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx_stream: CLK_FREQ/BAUD must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_check
      $error("uart_rx_stream: DATA_BITS must be in 5..8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
`ifdef UART_RX_STREAM_PARITY_EN
    ,
    S_PARITY = 3'd5
`endif
  } state_t;

  // Two-flop synchroniser; both stages reset to the idle (high) line level.
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_pin;
      rx_s_q    <= rx_meta_q;
    end
  end

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [3:0]            bits_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic [DATA_BITS-1:0]  data_q;
  logic                  valid_q;
  logic                  framing_err_q;
  logic                  overrun_q;
`ifdef UART_RX_STREAM_PARITY_EN
  logic                  parity_bit_q;
  logic                  parity_err_q;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bits_q        <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_STREAM_PARITY_EN
      parity_bit_q  <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_STREAM_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
      // Consumption; a byte completing in this same cycle overrides below.
      if (valid_q && ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= S_START;
          end
        end

        // Re-check the line half a bit in; a high level means a glitch.
        S_START: begin
          if (cnt_q == C_HALF_M1) begin
            cnt_q   <= '0;
            bits_q  <= '0;
            state_q <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt_q == C_CPB_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            bits_q  <= bits_q + 1'b1;
            if (bits_q == C_LAST_BIT) begin
`ifdef UART_RX_STREAM_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef UART_RX_STREAM_PARITY_EN
        S_PARITY: begin
          if (cnt_q == C_CPB_M1) begin
            cnt_q        <= '0;
            parity_bit_q <= rx_s_q;
            state_q      <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (cnt_q == C_CPB_M1) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              // Framing error takes priority over any parity error.
              framing_err_q <= 1'b1;
              state_q       <= S_BREAK;
            end else begin
              state_q <= S_IDLE;
`ifdef UART_RX_STREAM_PARITY_EN
              if (^{shift_q, parity_bit_q}) begin
                parity_err_q <= 1'b1;
              end else
`endif
              if (!valid_q || ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Held-low line: stay here so a break yields only one framing error.
        S_BREAK: begin
          cnt_q <= '0;
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
`ifdef UART_RX_STREAM_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

`default_nettype wire
